// File: rtl/rst_release_sequencer.sv
// Staged reset release sequencer.
// All stages are held in reset for HOLD_CYCLES cycles after rst_n
// deassertion or a software request. The stages are then released one at a
// time, bit 0 first, with STAGE_DELAY cycles between releases. Every output
// comes directly from a flop.
module rst_release_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned STAGE_DELAY = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sw_rst_req,
    output logic [NUM_STAGES-1:0]             stage_rst_n,
    output logic [$clog2(NUM_STAGES+1)-1:0]   released_cnt,
    output logic                              seq_done
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned RCW     = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0]  HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]  DELAY_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [RCW-1:0] LAST_IDX   = RCW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_d;
    logic [RCW-1:0]        rcnt_d;
    logic                  done_d;
    logic                  release_now;
    logic [NUM_STAGES:0]   stage_ext;

    // State, counter and output registers; rst_n clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            stage_rst_n  <= '0;
            released_cnt <= '0;
            seq_done     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_rst_n  <= stage_d;
            released_cnt <= rcnt_d;
            seq_done     <= done_d;
        end
    end

    // Next-state, counter and release decisions; software request wins over any release.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_rst_n;
        rcnt_d      = released_cnt;
        done_d      = seq_done;
        release_now = 1'b0;
        // Shifting a 1 in from the bottom keeps the release order strictly ascending.
        stage_ext   = {stage_rst_n, 1'b1};

        if (sw_rst_req) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            stage_d = '0;
            rcnt_d  = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        release_now = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == DELAY_LAST) begin
                        release_now = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase

            if (release_now) begin
                cnt_d   = '0;
                stage_d = stage_ext[NUM_STAGES-1:0];
                rcnt_d  = released_cnt + RCW'(1);
                // released_cnt counts stages already out of reset, so it
                // identifies the last stage before that stage is released.
                if (released_cnt == LAST_IDX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
        end
    end

endmodule

// File: tb/tb_rst_release_sequencer.sv
// Directed self-checking bench for rst_release_sequencer (default parameters).
module tb_rst_release_sequencer;

    logic       clk;
    logic       rst_n;
    logic       sw_rst_req;
    logic [3:0] stage_rst_n;
    logic [2:0] released_cnt;
    logic       seq_done;

    int unsigned total;
    int unsigned passed;

    rst_release_sequencer #(
        .NUM_STAGES  (4),
        .HOLD_CYCLES (8),
        .STAGE_DELAY (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst_req   (sw_rst_req),
        .stage_rst_n  (stage_rst_n),
        .released_cnt (released_cnt),
        .seq_done     (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected number of released stages after edge e (edge 1 = first counting edge).
    function automatic int unsigned exp_count(input int unsigned e);
        int unsigned c;
        if (e < 8) return 0;
        c = (e - 8) / 4 + 1;
        return (c > 4) ? 4 : c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stage"}, 32'(stage_rst_n), 32'h0);
        chk({tag, "_cnt"},   32'(released_cnt), 32'h0);
        chk({tag, "_done"},  32'(seq_done), 32'h0);
    endtask

    // Advance through edges first..last, checking every output against the release schedule.
    task automatic run_edges(input string tag, input int unsigned first, input int unsigned last);
        int unsigned c;
        for (int unsigned e = first; e <= last; e++) begin
            tick();
            c = exp_count(e);
            chk($sformatf("%s_e%0d_stage", tag, e), 32'(stage_rst_n), (32'd1 << c) - 32'd1);
            chk($sformatf("%s_e%0d_cnt", tag, e),   32'(released_cnt), c);
            chk($sformatf("%s_e%0d_done", tag, e),  32'(seq_done), (c == 4) ? 32'd1 : 32'd0);
        end
    endtask

    // One-cycle software request sampled on the next edge.
    task automatic sw_pulse(input string tag);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check_all_zero(tag);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;

        // Power-on: reset held for 3 cycles.
        #2;
        check_all_zero("por_async");
        repeat (3) tick();
        check_all_zero("por_hold");
        rst_n = 1'b1;
        run_edges("por", 1, 20);
        chk("por_final_stage", 32'(stage_rst_n), 32'hF);
        chk("por_final_cnt",   32'(released_cnt), 32'd4);
        repeat (3) tick();
        chk("done_stable_stage", 32'(stage_rst_n), 32'hF);
        chk("done_stable_done",  32'(seq_done), 32'd1);

        // Software reset from DONE, full replay.
        sw_pulse("sw_done");
        run_edges("sw_done", 1, 20);

        // Mid-sequence request on edge 14 (stage_rst_n=0011 before it).
        sw_pulse("mid_restart");
        run_edges("mid_pre", 1, 13);
        chk("mid_pre_stage", 32'(stage_rst_n), 32'h3);
        sw_pulse("mid_e14");
        run_edges("mid_replay", 1, 20);

        // Request colliding with the edge-12 release of bit 1.
        sw_pulse("col_restart");
        run_edges("col_pre", 1, 11);
        sw_pulse("col_e12");
        run_edges("col_replay", 1, 20);

        // Asynchronous reset between edges 17 and 18.
        sw_pulse("async_restart");
        run_edges("async_pre", 1, 17);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_drop");
        repeat (2) tick();
        check_all_zero("async_held");
        rst_n = 1'b1;
        run_edges("async_replay", 1, 20);

        // Software request held high for 5 cycles.
        sw_rst_req = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            check_all_zero($sformatf("held_%0d", i));
        end
        sw_rst_req = 1'b0;
        run_edges("held_replay", 1, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety net so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
